// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding and datapath widths.
package booth_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit to ptr is kept last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        any = 1'b1;
        idx = wrap_idx(ptr, k);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = any && (idx == IW'(gi));
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier between NUM_REQ requesters.
// Optional WAIT timeout with error response is enabled by defining MUL_TIMEOUT_EN.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [PROD_W-1:0]       rsp_data,
  output logic                    rsp_err,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic                    mul_done,
  input  logic [PROD_W-1:0]       mul_result
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("booth_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t              state_reg, state_next;
  logic [IW-1:0]       ptr_reg, grant_reg;
  logic [OP_W-1:0]     mul_a_reg, mul_b_reg;
  logic [PROD_W-1:0]   rsp_data_reg;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                accept, done_take, timeout_hit, rsp_take;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign accept    = (state_reg == IDLE) && pick_any && !rst;
  assign done_take = (state_reg == WAIT) && mul_done;
  assign rsp_take  = (state_reg == RESP) && rsp_ready[grant_reg];

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             rsp_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (accept) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // A genuine done on the final count still wins over the abort.
  assign timeout_hit = (state_reg == WAIT) && !mul_done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_reg <= 1'b0;
    end else if (done_take) begin
      rsp_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err_reg <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // SETTLE never looks at mul_done so a level left over from the last product is masked.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    mul_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          req_ready  = pick_gnt;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mul_start  = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: state_next = WAIT;
      WAIT: begin
        if (done_take || timeout_hit) state_next = RESP;
      end
      RESP: begin
        if (rsp_take) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_reg    <= '0;
      mul_b_reg    <= '0;
      grant_reg    <= '0;
      ptr_reg      <= '0;
      rsp_data_reg <= '0;
    end else begin
      if (accept) begin
        mul_a_reg <= req_a[int'(pick_idx)*OP_W +: OP_W];
        mul_b_reg <= req_b[int'(pick_idx)*OP_W +: OP_W];
        grant_reg <= pick_idx;
      end
      if (done_take) begin
        rsp_data_reg <= mul_result;
      end else if (timeout_hit) begin
        rsp_data_reg <= '0;
      end
      if (rsp_take) begin
        ptr_reg <= (grant_reg == IW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
    assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == IW'(gi));
  end

  assign rsp_data = rsp_data_reg;
  assign mul_a    = mul_a_reg;
  assign mul_b    = mul_b_reg;

endmodule
